// File: rtl/vgacpu_sim_pkg.sv
// Shared types for the vgacpu run controller: the top-level state machine and
// the reason code reported when a run ends.
package vgacpu_sim_pkg;

   typedef enum logic [1:0] {
      HOLD,
      RUN,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      END_NONE,
      END_CYCLES,
      END_FRAMES,
      END_STALL
   } end_reason_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/vgacpu_btn_seq.sv
// Round-robin button stimulus: a GAP phase (all released) followed by a PRESS
// phase on one channel, after which the channel index rotates.
module vgacpu_btn_seq
   import vgacpu_sim_pkg::*;
#(
   parameter int NUM_BTN        = 4,
   parameter int PRESS_CYCLES   = 1000,
   parameter int GAP_CYCLES     = 1000,
   parameter int BTN_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               step,
   output logic [NUM_BTN-1:0] buttons
);

   localparam int               IDX_W       = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_BTN - 1);
   localparam logic [31:0]      GAP_LAST    = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
   localparam logic [31:0]      PRESS_LAST  = (PRESS_CYCLES == 0) ? 32'd0 : 32'(PRESS_CYCLES - 1);
   localparam logic             START_PRESS = (GAP_CYCLES == 0) && (PRESS_CYCLES != 0);
   localparam logic             PRESSED     = (BTN_ACTIVE_LOW == 0);

   logic             in_press_reg;
   logic [31:0]      cnt_reg;
   logic [IDX_W-1:0] idx_reg;
   logic [IDX_W-1:0] idx_next;

   assign idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);

   // A zero-length phase is never entered: the other phase simply repeats.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_press_reg <= START_PRESS;
         cnt_reg      <= '0;
         idx_reg      <= '0;
      end else if (step) begin
         if (!in_press_reg) begin
            if (cnt_reg >= GAP_LAST) begin
               cnt_reg <= '0;
               if (PRESS_CYCLES != 0) begin
                  in_press_reg <= 1'b1;
               end else begin
                  idx_reg <= idx_next;
               end
            end else begin
               cnt_reg <= cnt_reg + 32'd1;
            end
         end else begin
            if (cnt_reg >= PRESS_LAST) begin
               cnt_reg <= '0;
               idx_reg <= idx_next;
               if (GAP_CYCLES != 0) begin
                  in_press_reg <= 1'b0;
               end
            end else begin
               cnt_reg <= cnt_reg + 32'd1;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
         assign buttons[gi] = (in_press_reg && (idx_reg == IDX_W'(gi))) ? PRESSED : ~PRESSED;
      end
   endgenerate

endmodule

// File: rtl/vgacpu_sim_ctrl.sv
// Run controller for vgacpu_top: releases DUT reset, drives button presses,
// counts cycles/frames, watches for a stall and flags the end of the run.
module vgacpu_sim_ctrl
   import vgacpu_sim_pkg::*;
#(
   parameter int              CNT_W          = 64,
   parameter longint unsigned MAX_CYCLES     = 1000000,
   parameter int unsigned     MAX_FRAMES     = 0,
   parameter int unsigned     WDOG_CYCLES    = 65536,
   parameter int              ACT_W          = 16,
   parameter int              NUM_BTN        = 4,
   parameter int              RST_HOLD       = 16,
   parameter int              PRESS_CYCLES   = 1000,
   parameter int              GAP_CYCLES     = 1000,
   parameter int              BTN_ACTIVE_LOW = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               vga_vsync,
   input  logic [ACT_W-1:0]   activity,
   output logic               dut_n_rst,
   output logic [NUM_BTN-1:0] buttons,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [31:0]        frame_count,
   output logic               done,
   output logic [1:0]         end_reason
);

   localparam logic [31:0] HOLD_LAST = (RST_HOLD <= 1) ? 32'd0 : 32'(RST_HOLD - 1);
   localparam logic        RELEASED  = (BTN_ACTIVE_LOW != 0);

   generate
      if (65'(MAX_CYCLES) >= (65'd1 << CNT_W)) begin : g_bad_max_cycles
         $error("MAX_CYCLES does not fit in CNT_W bits");
      end
   endgenerate

   state_t           state_reg;
   end_reason_t      end_reason_reg;
   end_reason_t      end_reason_next;
   logic [31:0]      hold_cnt_reg;
   logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
   logic [31:0]      frame_cnt_reg, frame_cnt_next;
   logic [31:0]      wdog_cnt_reg, wdog_cnt_next;
   logic             vsync_prev_reg;
   logic [ACT_W-1:0] act_prev_reg;
   logic             dut_n_rst_reg;
   logic             done_reg;
   logic             hit;
   logic [NUM_BTN-1:0] seq_buttons;

   vgacpu_btn_seq #(
      .NUM_BTN        (NUM_BTN),
      .PRESS_CYCLES   (PRESS_CYCLES),
      .GAP_CYCLES     (GAP_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
   ) u_btn_seq (
      .clk     (clk),
      .rst     (rst),
      .step    ((state_reg == RUN) && en),
      .buttons (seq_buttons)
   );

   // End conditions look at the values the counters take on this edge.
   always_comb begin
      cycle_cnt_next  = (cycle_cnt_reg == '1) ? cycle_cnt_reg : cycle_cnt_reg + CNT_W'(1);
      frame_cnt_next  = (vsync_prev_reg && !vga_vsync) ? sat_inc32(frame_cnt_reg) : frame_cnt_reg;
      wdog_cnt_next   = (activity != act_prev_reg) ? 32'd0 : sat_inc32(wdog_cnt_reg);
      end_reason_next = END_NONE;
      if (MAX_CYCLES != 0 && cycle_cnt_next == CNT_W'(MAX_CYCLES)) end_reason_next = END_CYCLES;
      if (MAX_FRAMES != 0 && frame_cnt_next == 32'(MAX_FRAMES))    end_reason_next = END_FRAMES;
      if (WDOG_CYCLES != 0 && wdog_cnt_next == 32'(WDOG_CYCLES))   end_reason_next = END_STALL;
      hit = (end_reason_next != END_NONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= HOLD;
         hold_cnt_reg   <= '0;
         cycle_cnt_reg  <= '0;
         frame_cnt_reg  <= '0;
         wdog_cnt_reg   <= '0;
         vsync_prev_reg <= 1'b1;
         act_prev_reg   <= '0;
         dut_n_rst_reg  <= 1'b0;
         done_reg       <= 1'b0;
         end_reason_reg <= END_NONE;
      end else begin
         vsync_prev_reg <= vga_vsync;
         act_prev_reg   <= activity;
         if (en) begin
            unique case (state_reg)
               HOLD: begin
                  if (hold_cnt_reg >= HOLD_LAST) begin
                     state_reg     <= RUN;
                     dut_n_rst_reg <= 1'b1;
                  end else begin
                     hold_cnt_reg <= hold_cnt_reg + 32'd1;
                  end
               end
               RUN: begin
                  cycle_cnt_reg <= cycle_cnt_next;
                  frame_cnt_reg <= frame_cnt_next;
                  wdog_cnt_reg  <= wdog_cnt_next;
                  if (hit) begin
                     state_reg      <= DONE;
                     done_reg       <= 1'b1;
                     end_reason_reg <= end_reason_next;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign dut_n_rst   = dut_n_rst_reg;
   assign buttons     = (state_reg == RUN) ? seq_buttons : {NUM_BTN{RELEASED}};
   assign cycle_count = cycle_cnt_reg;
   assign frame_count = frame_cnt_reg;
   assign done        = done_reg;
   assign end_reason  = end_reason_reg;

endmodule

// File: tb/tb_vgacpu_sim_ctrl.sv
// Directed bench for vgacpu_sim_ctrl: every step pushes the expected outputs of
// the next cycle to a scoreboard, which is popped and compared after the edge.
module tb_vgacpu_sim_ctrl;

   logic        clk = 1'b0;
   logic        rst, en, vga_vsync;
   logic [15:0] activity;
   logic        dut_n_rst;
   logic [1:0]  buttons;
   logic [15:0] cycle_count;
   logic [31:0] frame_count;
   logic        done;
   logic [1:0]  end_reason;

   always #5 clk = ~clk;

   vgacpu_sim_ctrl #(
      .CNT_W          (16),
      .MAX_CYCLES     (10),
      .MAX_FRAMES     (3),
      .WDOG_CYCLES    (5),
      .ACT_W          (16),
      .NUM_BTN        (2),
      .RST_HOLD       (4),
      .PRESS_CYCLES   (3),
      .GAP_CYCLES     (2),
      .BTN_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .vga_vsync   (vga_vsync),
      .activity    (activity),
      .dut_n_rst   (dut_n_rst),
      .buttons     (buttons),
      .cycle_count (cycle_count),
      .frame_count (frame_count),
      .done        (done),
      .end_reason  (end_reason)
   );

   typedef struct {
      string      tag;
      logic       e_n_rst;
      logic [1:0] e_btn;
      logic       e_done;
      logic [1:0] e_reason;
      int         e_cyc;
      int         e_frm;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   act_ctr = 0;

   // Button pattern seen in RUN cycles 0..9 (GAP=2, PRESS=3, two channels, active-low).
   logic [1:0] btn_seq [0:9] = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10,
                                  2'b11, 2'b11, 2'b01, 2'b01, 2'b01};

   function automatic exp_t mk(string tag, logic n, logic [1:0] b, logic d,
                               logic [1:0] r, int cyc, int frm);
      exp_t x;
      x.tag = tag; x.e_n_rst = n; x.e_btn = b; x.e_done = d;
      x.e_reason = r; x.e_cyc = cyc; x.e_frm = frm;
      return x;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic step(input logic r_in, input logic e, input logic v,
                       input logic [15:0] a, input exp_t x);
      exp_t got;
      rst = r_in; en = e; vga_vsync = v; activity = a;
      sb.push_back(x);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check({got.tag, ".n_rst"},  64'(dut_n_rst),   64'(got.e_n_rst));
      check({got.tag, ".btn"},    64'(buttons),     64'(got.e_btn));
      check({got.tag, ".done"},   64'(done),        64'(got.e_done));
      check({got.tag, ".reason"}, 64'(end_reason),  64'(got.e_reason));
      check({got.tag, ".cycles"}, 64'(cycle_count), 64'(got.e_cyc));
      check({got.tag, ".frames"}, 64'(frame_count), 64'(got.e_frm));
   endtask

   task automatic do_reset(string tag);
      step(1'b1, 1'b1, 1'b1, 16'(act_ctr), mk(tag, 1'b0, 2'b11, 1'b0, 2'd0, 0, 0));
   endtask

   // Four enabled HOLD cycles; the output after the fourth edge is RUN cycle 0.
   task automatic do_hold(string tag);
      for (int c = 0; c < 4; c++) begin
         act_ctr++;
         step(1'b0, 1'b1, 1'b1, 16'(act_ctr),
              mk($sformatf("%s.hold%0d", tag, c + 1), (c == 3), 2'b11, 1'b0, 2'd0, 0, 0));
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; vga_vsync = 1'b1; activity = '0;
      do_reset("reset0");
      do_reset("reset1");

      // Cycle limit with rotating buttons and an en=0 pause mid-PRESS.
      do_hold("A");
      for (int r = 0; r < 10; r++) begin
         if (r == 3) begin
            for (int k = 0; k < 4; k++) begin
               act_ctr++;
               step(1'b0, 1'b0, 1'b1, 16'(act_ctr),
                    mk($sformatf("A.en0_%0d", k), 1'b1, btn_seq[3], 1'b0, 2'd0, 3, 0));
            end
         end
         act_ctr++;
         if (r < 9)
            step(1'b0, 1'b1, 1'b1, 16'(act_ctr),
                 mk($sformatf("A.run%0d", r + 1), 1'b1, btn_seq[r + 1], 1'b0, 2'd0, r + 1, 0));
         else
            step(1'b0, 1'b1, 1'b1, 16'(act_ctr), mk("A.done", 1'b1, 2'b11, 1'b1, 2'd1, 10, 0));
      end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b1, k[0], 16'(act_ctr),
              mk($sformatf("A.frozen%0d", k), 1'b1, 2'b11, 1'b1, 2'd1, 10, 0));
      end

      // Reset out of DONE, then frame limit: vsync falls at RUN cycles 0, 4, 8.
      do_reset("B.rst_done");
      do_hold("B");
      for (int r = 0; r < 9; r++) begin
         act_ctr++;
         if (r < 8)
            step(1'b0, 1'b1, ((r % 4) >= 2), 16'(act_ctr),
                 mk($sformatf("B.run%0d", r + 1), 1'b1, btn_seq[r + 1], 1'b0, 2'd0, r + 1, r / 4 + 1));
         else
            step(1'b0, 1'b1, 1'b0, 16'(act_ctr), mk("B.done", 1'b1, 2'b11, 1'b1, 2'd2, 9, 3));
      end
      for (int k = 0; k < 2; k++) begin
         act_ctr++;
         step(1'b0, 1'b1, 1'b1, 16'(act_ctr),
              mk($sformatf("B.frozen%0d", k), 1'b1, 2'b11, 1'b1, 2'd2, 9, 3));
      end

      // Reset in the middle of RUN.
      do_reset("C.rst0");
      do_hold("C");
      for (int r = 0; r < 3; r++) begin
         act_ctr++;
         step(1'b0, 1'b1, 1'b1, 16'(act_ctr),
              mk($sformatf("C.run%0d", r + 1), 1'b1, btn_seq[r + 1], 1'b0, 2'd0, r + 1, 0));
      end
      do_reset("C.rst_run");

      // Stall: activity frozen from RUN cycle 2, watchdog reaches 5 on the edge ending cycle 6.
      do_hold("D");
      for (int r = 0; r < 7; r++) begin
         if (r < 2) act_ctr++;
         if (r < 6)
            step(1'b0, 1'b1, 1'b1, 16'(act_ctr),
                 mk($sformatf("D.run%0d", r + 1), 1'b1, btn_seq[r + 1], 1'b0, 2'd0, r + 1, 0));
         else
            step(1'b0, 1'b1, 1'b1, 16'(act_ctr), mk("D.stall", 1'b1, 2'b11, 1'b1, 2'd3, 7, 0));
      end

      // Stall and cycle limit on the same edge: stall wins.
      do_reset("E.rst");
      do_hold("E");
      for (int r = 0; r < 10; r++) begin
         if (r < 5) act_ctr++;
         if (r < 9)
            step(1'b0, 1'b1, 1'b1, 16'(act_ctr),
                 mk($sformatf("E.run%0d", r + 1), 1'b1, btn_seq[r + 1], 1'b0, 2'd0, r + 1, 0));
         else
            step(1'b0, 1'b1, 1'b1, 16'(act_ctr), mk("E.prio", 1'b1, 2'b11, 1'b1, 2'd3, 10, 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
